cmd_arbiter: RTL and testbench



---
 rtl/cmd_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_cmd_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_arbiter
//   Two-port round-robin arbiter in front of the command FIFO push interface.
//   Merges the command streams of requester port 0 and port 1 into a single
//   valid/ready stream. A multi-beat write burst (head beat plus burst_cnt data
//   beats) locks the grant to its port until the last beat is accepted, so the
//   burst reaches the FIFO contiguously. A single registered output stage
//   isolates the FIFO timing path.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_rdy    requester N handshake (beat taken on valid && rdy)
//   reqN_cmd_type            1 = write, 0 = read
//   reqN_addr                command address
//   reqN_burst_cnt           extra data beats for a write (0 = single beat)
//   reqN_wt_data/_wt_mask    write data / byte mask
//   push_valid / push_rdy    output stage handshake towards the FIFO
//   push_*                   registered beat fields, push_port = source port
// -----------------------------------------------------------------------------
module cmd_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int BURST_W = 6,
  parameter int DATA_W  = 128,
  parameter int MASK_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  // requester port 0
  input  logic               req0_valid,
  output logic               req0_rdy,
  input  logic               req0_cmd_type,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [BURST_W-1:0] req0_burst_cnt,
  input  logic [DATA_W-1:0]  req0_wt_data,
  input  logic [MASK_W-1:0]  req0_wt_mask,
  // requester port 1
  input  logic               req1_valid,
  output logic               req1_rdy,
  input  logic               req1_cmd_type,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [BURST_W-1:0] req1_burst_cnt,
  input  logic [DATA_W-1:0]  req1_wt_data,
  input  logic [MASK_W-1:0]  req1_wt_mask,
  // FIFO push side
  output logic               push_valid,
  input  logic               push_rdy,
  output logic               push_cmd_type,
  output logic [ADDR_W-1:0]  push_addr,
  output logic [BURST_W-1:0] push_burst_cnt,
  output logic [DATA_W-1:0]  push_wt_data,
  output logic [MASK_W-1:0]  push_wt_mask,
  output logic               push_port
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic [BURST_W-1:0] BEAT_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;

  logic               push_valid_q;
  logic               push_cmd_type_q;
  logic [ADDR_W-1:0]  push_addr_q;
  logic [BURST_W-1:0] push_burst_cnt_q;
  logic [DATA_W-1:0]  push_wt_data_q;
  logic [MASK_W-1:0]  push_wt_mask_q;
  logic               push_port_q;

  logic               gnt_vld_s;
  logic               gnt_port_s;
  logic               can_load_s;
  logic               accept_s;
  logic               sel_cmd_type_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [BURST_W-1:0] sel_burst_cnt_s;
  logic [DATA_W-1:0]  sel_wt_data_s;
  logic [MASK_W-1:0]  sel_wt_mask_s;

  // Grant selection. A locked state grants its port regardless of valid, so
  // the other port can never slip a beat into the middle of a burst.
  always_comb begin
    gnt_vld_s  = 1'b0;
    gnt_port_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt_vld_s  = 1'b1;
          gnt_port_s = prio_q;
        end else if (req0_valid) begin
          gnt_vld_s  = 1'b1;
          gnt_port_s = 1'b0;
        end else if (req1_valid) begin
          gnt_vld_s  = 1'b1;
          gnt_port_s = 1'b1;
        end else begin
          gnt_vld_s  = 1'b0;
          gnt_port_s = 1'b0;
        end
      end
      ST_LOCK0: begin
        gnt_vld_s  = 1'b1;
        gnt_port_s = 1'b0;
      end
      ST_LOCK1: begin
        gnt_vld_s  = 1'b1;
        gnt_port_s = 1'b1;
      end
      default: begin
        gnt_vld_s  = 1'b0;
        gnt_port_s = 1'b0;
      end
    endcase
  end

  // The stage can take a beat when empty or when its beat leaves this cycle.
  assign can_load_s = !push_valid_q || push_rdy;

  // rst gating keeps both rdy low for the whole time reset is held.
  assign req0_rdy = !rst && can_load_s && gnt_vld_s && !gnt_port_s;
  assign req1_rdy = !rst && can_load_s && gnt_vld_s &&  gnt_port_s;

  assign accept_s = (req0_valid && req0_rdy) || (req1_valid && req1_rdy);

  // Field mux from the granted port.
  always_comb begin
    if (gnt_port_s) begin
      sel_cmd_type_s  = req1_cmd_type;
      sel_addr_s      = req1_addr;
      sel_burst_cnt_s = req1_burst_cnt;
      sel_wt_data_s   = req1_wt_data;
      sel_wt_mask_s   = req1_wt_mask;
    end else begin
      sel_cmd_type_s  = req0_cmd_type;
      sel_addr_s      = req0_addr;
      sel_burst_cnt_s = req0_burst_cnt;
      sel_wt_data_s   = req0_wt_data;
      sel_wt_mask_s   = req0_wt_mask;
    end
  end

  // Next state, priority and burst beat counter.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    if (accept_s) begin
      case (state_q)
        ST_IDLE: begin
          if (sel_cmd_type_s && (sel_burst_cnt_s != '0)) begin
            // Burst head: lock to this port, priority stays until the end.
            beat_cnt_d = sel_burst_cnt_s;
            state_d    = gnt_port_s ? ST_LOCK1 : ST_LOCK0;
          end else begin
            prio_d = ~gnt_port_s;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          beat_cnt_d = beat_cnt_q - BEAT_ONE;
          if (beat_cnt_q == BEAT_ONE) begin
            state_d = ST_IDLE;
            prio_d  = ~gnt_port_s;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output stage: load on accept, otherwise drain when the FIFO takes it.
  // Fields are only written on load, so they hold while push_rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_valid_q     <= 1'b0;
      push_cmd_type_q  <= 1'b0;
      push_addr_q      <= '0;
      push_burst_cnt_q <= '0;
      push_wt_data_q   <= '0;
      push_wt_mask_q   <= '0;
      push_port_q      <= 1'b0;
    end else if (accept_s) begin
      push_valid_q     <= 1'b1;
      push_cmd_type_q  <= sel_cmd_type_s;
      push_addr_q      <= sel_addr_s;
      push_burst_cnt_q <= sel_burst_cnt_s;
      push_wt_data_q   <= sel_wt_data_s;
      push_wt_mask_q   <= sel_wt_mask_s;
      push_port_q      <= gnt_port_s;
    end else if (push_rdy) begin
      push_valid_q <= 1'b0;
    end
  end

  assign push_valid     = push_valid_q;
  assign push_cmd_type  = push_cmd_type_q;
  assign push_addr      = push_addr_q;
  assign push_burst_cnt = push_burst_cnt_q;
  assign push_wt_data   = push_wt_data_q;
  assign push_wt_mask   = push_wt_mask_q;
  assign push_port      = push_port_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmd_arbiter
//   Scoreboard bench for cmd_arbiter. Each port is fed from a queue of beats
//   (commands plus their burst data beats, with optional idle gaps). A
//   reference model, run on every rising edge from the inputs alone, decides
//   which beat the arbiter should take and pushes it into the scoreboard. A
//   monitor on the falling edge compares the output stage and both rdy lines.
// -----------------------------------------------------------------------------
module tb_cmd_arbiter;
  localparam int ADDR_W  = 27;
  localparam int BURST_W = 6;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = 16;
  localparam int BEAT_W  = 1 + ADDR_W + BURST_W + DATA_W + MASK_W + 1;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef struct {
    logic               typ;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [DATA_W-1:0]  data;
    logic [MASK_W-1:0]  mask;
    int                 gap;
  } src_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic               req0_rdy, req1_rdy;
  logic               req0_cmd_type = 1'b0, req1_cmd_type = 1'b0;
  logic [ADDR_W-1:0]  req0_addr = '0, req1_addr = '0;
  logic [BURST_W-1:0] req0_burst_cnt = '0, req1_burst_cnt = '0;
  logic [DATA_W-1:0]  req0_wt_data = '0, req1_wt_data = '0;
  logic [MASK_W-1:0]  req0_wt_mask = '0, req1_wt_mask = '0;
  logic               push_valid;
  logic               push_rdy = 1'b1;
  logic               push_cmd_type;
  logic [ADDR_W-1:0]  push_addr;
  logic [BURST_W-1:0] push_burst_cnt;
  logic [DATA_W-1:0]  push_wt_data;
  logic [MASK_W-1:0]  push_wt_mask;
  logic               push_port;

  cmd_arbiter #(
    .ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rdy(req0_rdy), .req0_cmd_type(req0_cmd_type),
    .req0_addr(req0_addr), .req0_burst_cnt(req0_burst_cnt),
    .req0_wt_data(req0_wt_data), .req0_wt_mask(req0_wt_mask),
    .req1_valid(req1_valid), .req1_rdy(req1_rdy), .req1_cmd_type(req1_cmd_type),
    .req1_addr(req1_addr), .req1_burst_cnt(req1_burst_cnt),
    .req1_wt_data(req1_wt_data), .req1_wt_mask(req1_wt_mask),
    .push_valid(push_valid), .push_rdy(push_rdy), .push_cmd_type(push_cmd_type),
    .push_addr(push_addr), .push_burst_cnt(push_burst_cnt),
    .push_wt_data(push_wt_data), .push_wt_mask(push_wt_mask), .push_port(push_port)
  );

  always #5 clk = ~clk;

  int    checks_total  = 0;
  int    checks_passed = 0;
  int    p1_cnt        = 0;
  int    hold_cnt      = 0;
  bit    rnd_rdy       = 1'b0;
  src_t  pq0[$];
  src_t  pq1[$];
  beat_t sb[$];

  // Reference model state: which port owns an open burst (-1 = none), how
  // many burst data beats are still owed, round-robin priority, stage full.
  int    m_lock = -1;
  int    m_left = 0;
  int    m_prio = 0;
  bit    m_full = 1'b0;

  task automatic check(input string name, input beat_t act, input beat_t exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int model_grant();
    if (m_lock >= 0) return m_lock;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] model_rdy();
    logic [1:0] r;
    int g;
    r = 2'b00;
    g = model_grant();
    if (g >= 0 && (!m_full || push_rdy)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    int    g;
    bit    acc;
    beat_t b;
    logic  typ;
    logic [BURST_W-1:0] bc;
    g   = model_grant();
    acc = (g >= 0) && (!m_full || push_rdy) && ((g == 0) ? req0_valid : req1_valid);
    if (acc) begin
      if (g == 0) begin
        typ = req0_cmd_type; bc = req0_burst_cnt;
        b = {req0_cmd_type, req0_addr, req0_burst_cnt, req0_wt_data, req0_wt_mask, 1'b0};
      end else begin
        typ = req1_cmd_type; bc = req1_burst_cnt;
        b = {req1_cmd_type, req1_addr, req1_burst_cnt, req1_wt_data, req1_wt_mask, 1'b1};
      end
      sb.push_back(b);
      if (m_lock < 0) begin
        if (typ && bc != 0) begin
          m_lock = g;
          m_left = int'(bc);
        end else begin
          m_prio = 1 - g;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_lock = -1;
          m_prio = 1 - g;
        end
      end
    end
    m_full = acc ? 1'b1 : (push_rdy ? 1'b0 : m_full);
  endtask

  // Reference model, evaluated on the inputs present at each rising edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_lock = -1; m_left = 0; m_prio = 0; m_full = 1'b0;
      sb.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compares rdy lines and the output stage against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("req_rdy", BEAT_W'({req1_rdy, req0_rdy}), BEAT_W'(model_rdy()));
      check("push_valid", BEAT_W'(push_valid), BEAT_W'(sb.size() != 0));
      if (push_valid && sb.size() != 0) begin
        check("push_beat",
              {push_cmd_type, push_addr, push_burst_cnt, push_wt_data, push_wt_mask, push_port},
              sb[0]);
        if (push_rdy) void'(sb.pop_front());
      end
      if (push_valid && push_port) p1_cnt++;
    end
  end

  function automatic src_t rand_beat();
    src_t s;
    s.typ   = 1'($urandom());
    s.addr  = ADDR_W'($urandom());
    s.burst = BURST_W'($urandom());
    s.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    s.mask  = MASK_W'($urandom());
    s.gap   = 0;
    return s;
  endfunction

  // Queue a command (and, for a write, its burst data beats) on port p.
  task automatic add_cmd(input int p, input logic wr, input logic [BURST_W-1:0] burst,
                         input int gap);
    src_t s;
    s = rand_beat();
    s.typ = wr; s.burst = burst; s.gap = gap;
    if (p == 0) pq0.push_back(s); else pq1.push_back(s);
    if (wr) begin
      for (int k = 0; k < int'(burst); k++) begin
        s = rand_beat();
        if (p == 0) pq0.push_back(s); else pq1.push_back(s);
      end
    end
  endtask

  task automatic present();
    if (pq0.size() != 0 && pq0[0].gap == 0) begin
      req0_valid = 1'b1; req0_cmd_type = pq0[0].typ; req0_addr = pq0[0].addr;
      req0_burst_cnt = pq0[0].burst; req0_wt_data = pq0[0].data; req0_wt_mask = pq0[0].mask;
    end else begin
      req0_valid = 1'b0;
      if (pq0.size() != 0) pq0[0].gap = pq0[0].gap - 1;
    end
    if (pq1.size() != 0 && pq1[0].gap == 0) begin
      req1_valid = 1'b1; req1_cmd_type = pq1[0].typ; req1_addr = pq1[0].addr;
      req1_burst_cnt = pq1[0].burst; req1_wt_data = pq1[0].data; req1_wt_mask = pq1[0].mask;
    end else begin
      req1_valid = 1'b0;
      if (pq1.size() != 0) pq1[0].gap = pq1[0].gap - 1;
    end
    if (hold_cnt > 0) begin
      push_rdy = 1'b0;
      hold_cnt--;
    end else if (rnd_rdy) begin
      push_rdy = ($urandom_range(0, 3) != 0);
    end else begin
      push_rdy = 1'b1;
    end
  endtask

  // One clock: drive after the rising edge, observe the handshake mid-cycle.
  task automatic run_cycles(input int n);
    bit a0, a1;
    repeat (n) begin
      present();
      @(negedge clk);
      a0 = req0_valid && req0_rdy;
      a1 = req1_valid && req1_rdy;
      @(posedge clk);
      #1;
      if (a0) void'(pq0.pop_front());
      if (a1) void'(pq1.pop_front());
    end
  endtask

  task automatic run_until_empty(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0) && n < max_cycles) begin
      run_cycles(1);
      n++;
    end
    check(name, BEAT_W'(pq0.size() + pq1.size() + sb.size()), BEAT_W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: valids held high to show rdy stays low while rst is asserted.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_push_valid", BEAT_W'(push_valid), BEAT_W'(0));
    check("rst_fields",
          {push_cmd_type, push_addr, push_burst_cnt, push_wt_data, push_wt_mask, push_port},
          BEAT_W'(0));
    check("rst_rdy", BEAT_W'({req1_rdy, req0_rdy}), BEAT_W'(0));
    @(negedge clk);
    #2;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;

    // Both ports issue reads every cycle: strict alternation starting at port 0.
    for (int i = 0; i < 12; i++) begin
      add_cmd(0, 1'b0, BURST_W'($urandom()), 0);
      add_cmd(1, 1'b0, BURST_W'($urandom()), 0);
    end
    run_until_empty("alt_drain", 100);

    // Port 0 write burst of 4 beats, 2-cycle stall before its third beat,
    // while port 1 waits with a read.
    add_cmd(0, 1'b1, 6'd3, 0);
    pq0[2].gap = 2;
    add_cmd(1, 1'b0, 6'd0, 0);
    run_until_empty("burst_drain", 100);

    // Full stage held with push_rdy low for 5 cycles, then drained and
    // reloaded in the same cycle.
    hold_cnt = 6;
    add_cmd(0, 1'b0, 6'd0, 0);
    add_cmd(0, 1'b1, 6'd0, 0);
    add_cmd(1, 1'b0, 6'd0, 0);
    run_until_empty("hold_drain", 100);

    // Asynchronous reset in the middle of a 6-beat burst (2 beats still owed).
    add_cmd(0, 1'b1, 6'd5, 0);
    run_cycles(4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_push_valid", BEAT_W'(push_valid), BEAT_W'(0));
    check("async_rst_rdy", BEAT_W'({req1_rdy, req0_rdy}), BEAT_W'(0));
    pq0.delete(); pq1.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    add_cmd(0, 1'b0, 6'd0, 0);
    add_cmd(1, 1'b0, 6'd0, 0);
    add_cmd(0, 1'b0, 6'd0, 0);
    add_cmd(1, 1'b0, 6'd0, 0);
    run_until_empty("post_rst_drain", 100);
    run_cycles(2);

    // Port 1 alone: 10 single-beat writes must stream on consecutive cycles.
    for (int i = 0; i < 10; i++) add_cmd(1, 1'b1, 6'd0, 0);
    p1_cnt = 0;
    run_cycles(11);
    check("p1_stream_beats", BEAT_W'(p1_cnt), BEAT_W'(10));
    check("p1_stream_left", BEAT_W'(pq1.size()), BEAT_W'(0));
    run_until_empty("p1_drain", 50);

    // Randomised traffic with random FIFO back-pressure, including a maximum
    // length burst of 64 beats.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1)
          add_cmd(p, 1'b1,
                  ($urandom_range(0, 3) == 0) ? BURST_W'($urandom_range(1, 5)) : BURST_W'(0),
                  $urandom_range(0, 2));
        else
          add_cmd(p, 1'b0, BURST_W'($urandom()), $urandom_range(0, 2));
      end
      if (i == 15) add_cmd(1, 1'b1, 6'd63, 0);
    end
    run_until_empty("random_drain", 3000);
    rnd_rdy = 1'b0;
    run_until_empty("final_drain", 50);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
